// File: rtl/npu_scan_pkg.sv
// ---------------------------------------------------------------------------
// npu_scan_pkg
// Shared types for the RRAM array scan sequencer.
//   op_e        : per-slot operation code (also the srref mux select value)
//   pulse_cfg_t : per-operation pulse width and WL/SEL/BL window bounds
//   state_e     : sequencer FSM states
//   PW_W        : width of every pulse_cfg_t field and of the pulse counter
//   ACC_W       : width of the READMEM accumulator (READ_ACCUM_EN builds)
//   sat_add     : unsigned saturating add used by the accumulator
// No ports (package).
// ---------------------------------------------------------------------------
package npu_scan_pkg;

    localparam int PW_W  = 16;
    localparam int ACC_W = 16;

    typedef enum logic [1:0] {
        OP_SET     = 2'd0,
        OP_RESET   = 2'd1,
        OP_READMEM = 2'd2,
        OP_NOP     = 2'd3
    } op_e;

    typedef struct packed {
        logic [PW_W-1:0] pw;
        logic [PW_W-1:0] wl_st;
        logic [PW_W-1:0] wl_end;
        logic [PW_W-1:0] sel_st;
        logic [PW_W-1:0] sel_end;
        logic [PW_W-1:0] bl_st;
        logic [PW_W-1:0] bl_end;
    } pulse_cfg_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_SETUP,
        S_PULSE,
        S_ADC_FIRST,
        S_ADC_HIGH,
        S_ADC_LOW,
        S_PUSH,
        S_NEXT,
        S_DONE
    } state_e;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/npu_pulse_window_gen.sv
// ---------------------------------------------------------------------------
// npu_pulse_window_gen
// Pulse counter plus three window comparators. While run is high the counter
// steps 0..cfg.pw; each enable is high while st <= cnt <= min(end, pw).
// A window with st > end never asserts. The counter returns to 0 whenever run
// is low, so every PULSE phase starts from 0.
// Ports:
//   clk, rst_n         clock, asynchronous active-high reset
//   run                high for the whole PULSE phase
//   cfg                pulse configuration of the current operation
//   last               counter has reached cfg.pw (final pulse cycle)
//   wl_en/sel_en/bl_en window enables
// ---------------------------------------------------------------------------
module npu_pulse_window_gen
    import npu_scan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  pulse_cfg_t cfg,
    output logic       last,
    output logic       wl_en,
    output logic       sel_en,
    output logic       bl_en
);

    logic [PW_W-1:0] cnt_q, cnt_d;

    function automatic logic in_win(input logic [PW_W-1:0] cnt,
                                    input logic [PW_W-1:0] w_st,
                                    input logic [PW_W-1:0] w_end,
                                    input logic [PW_W-1:0] pw);
        logic [PW_W-1:0] end_clip;
        end_clip = (w_end > pw) ? pw : w_end;
        return (cnt >= w_st) && (cnt <= end_clip);
    endfunction

    always_comb begin
        cnt_d = run ? cnt_q + PW_W'(1) : '0;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    always_comb begin
        last   = run && (cnt_q == cfg.pw);
        wl_en  = run && in_win(cnt_q, cfg.wl_st,  cfg.wl_end,  cfg.pw);
        sel_en = run && in_win(cnt_q, cfg.sel_st, cfg.sel_end, cfg.pw);
        bl_en  = run && in_win(cnt_q, cfg.bl_st,  cfg.bl_end,  cfg.pw);
    end

endmodule

// File: rtl/npu_array_scan_seq.sv
// ---------------------------------------------------------------------------
// npu_array_scan_seq
// Scans the WL x BL rectangle [cfg_wl_st..cfg_wl_end] x [cfg_bl_st..cfg_bl_end]
// and runs up to NUM_SLOTS operations (SET/RESET/READMEM/NOP) per point.
// Iteration order, innermost first: slot, L1 repeat, BL, WL, L4 repeat.
// READMEM results leave on a valid/ready stream as {wl, bl, result}.
//
// Optional build macro READ_ACCUM_EN: READMEM results of one point (all slots,
// all L1 repeats) are summed in a 16-bit saturating accumulator and pushed once
// per point; rd_data then carries {wl, bl, acc16}.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-high reset
//   start, abort          one-cycle controls (abort wins)
//   cfg_*                 scan range, slots, pulse windows, loops, ADC timing
//   wl_addr, bl_addr      current array point
//   wl_en/sel_en/bl_en    pulse windows; set_o/reset_o ground enables
//   clkadc, op_sel        ADC clock, current operation
//   dout                  ADC result input
//   rd_valid/ready/data   result stream
//   busy, done, err       status; st_slot/st_l1/st_l4 loop status
// ---------------------------------------------------------------------------
module npu_array_scan_seq
    import npu_scan_pkg::*;
#(
    parameter int WL_W      = 8,
    parameter int BL_W      = 8,
    parameter int NUM_SLOTS = 4,
    parameter int DOUT_W    = 6,
    parameter int LOOP_W    = 32,
    parameter int ADC_DLY_W = 12,
`ifdef READ_ACCUM_EN
    localparam int RES_W    = ACC_W
`else
    localparam int RES_W    = DOUT_W
`endif
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [WL_W-1:0]           cfg_wl_st,
    input  logic [WL_W-1:0]           cfg_wl_end,
    input  logic [BL_W-1:0]           cfg_bl_st,
    input  logic [BL_W-1:0]           cfg_bl_end,
    input  logic [2:0]                cfg_slot_num,
    input  logic [2*NUM_SLOTS-1:0]    cfg_slot_mode,
    input  pulse_cfg_t [2:0]          cfg_pulse,
    input  logic [LOOP_W-1:0]         cfg_l1_loop,
    input  logic [LOOP_W-1:0]         cfg_l4_loop,
    input  logic [ADC_DLY_W-1:0]      cfg_adc_first,
    input  logic [ADC_DLY_W-1:0]      cfg_adc_high,
    input  logic [ADC_DLY_W-1:0]      cfg_adc_low,
    output logic [WL_W-1:0]           wl_addr,
    output logic [BL_W-1:0]           bl_addr,
    output logic                      wl_en,
    output logic                      sel_en,
    output logic                      bl_en,
    output logic                      set_o,
    output logic                      reset_o,
    output logic                      clkadc,
    output logic [1:0]                op_sel,
    input  logic [DOUT_W-1:0]         dout,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [WL_W+BL_W+RES_W-1:0] rd_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [2:0]                st_slot,
    output logic [LOOP_W-1:0]         st_l1,
    output logic [LOOP_W-1:0]         st_l4
);

    localparam logic [2:0] SLOTS_3 = 3'(NUM_SLOTS);

    state_e                state_q, state_d;
    logic [WL_W-1:0]       wl_q, wl_d;
    logic [BL_W-1:0]       bl_q, bl_d;
    logic [2:0]            slot_q, slot_d;
    logic [LOOP_W-1:0]     l1_q, l1_d, l4_q, l4_d;
    logic [ADC_DLY_W-1:0]  cnt_q, cnt_d;
    logic [RES_W-1:0]      res_q, res_d;
    logic                  err_q, err_d;
    logic                  acc_vld_q, acc_vld_d;   // point holds >=1 READMEM sum

    op_e        cur_op;
    pulse_cfg_t pcfg;
    logic       pulse_last, point_last, push_pt, cfg_bad;
    state_e     after_adc;

    // Slot decode and pulse-config select for the current operation.
    always_comb begin
        cur_op = OP_NOP;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q == 3'(i)) cur_op = op_e'(cfg_slot_mode[2*i +: 2]);
        end
        case (cur_op)
            OP_RESET:   pcfg = cfg_pulse[1];
            OP_READMEM: pcfg = cfg_pulse[2];
            default:    pcfg = cfg_pulse[0];
        endcase
    end

    npu_pulse_window_gen u_pulse (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state_q == S_PULSE),
        .cfg    (pcfg),
        .last   (pulse_last),
        .wl_en  (wl_en),
        .sel_en (sel_en),
        .bl_en  (bl_en)
    );

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= S_IDLE;
            wl_q      <= '0;
            bl_q      <= '0;
            slot_q    <= '0;
            l1_q      <= '0;
            l4_q      <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            err_q     <= 1'b0;
            acc_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wl_q      <= wl_d;
            bl_q      <= bl_d;
            slot_q    <= slot_d;
            l1_q      <= l1_d;
            l4_q      <= l4_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            err_q     <= err_d;
            acc_vld_q <= acc_vld_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        wl_d      = wl_q;
        bl_d      = bl_q;
        slot_d    = slot_q;
        l1_d      = l1_q;
        l4_d      = l4_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        err_d     = err_q;
        acc_vld_d = acc_vld_q;
        push_pt   = 1'b0;

        cfg_bad    = (cfg_wl_end < cfg_wl_st) || (cfg_bl_end < cfg_bl_st) ||
                     (cfg_slot_num == 3'd0) || (cfg_slot_num > SLOTS_3);
        point_last = (slot_q == cfg_slot_num - 3'd1) && (l1_q == cfg_l1_loop);
`ifdef READ_ACCUM_EN
        after_adc  = S_NEXT;
`else
        after_adc  = S_PUSH;
`endif

        case (state_q)
            S_IDLE: if (start) state_d = S_CHECK;
            S_CHECK: begin
                err_d = cfg_bad;
                if (cfg_bad) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_SETUP;
                    wl_d      = cfg_wl_st;
                    bl_d      = cfg_bl_st;
                    slot_d    = '0;
                    l1_d      = '0;
                    l4_d      = '0;
                    cnt_d     = '0;
                    res_d     = '0;
                    acc_vld_d = 1'b0;
                end
            end
            S_SETUP: state_d = (cur_op == OP_NOP) ? S_NEXT : S_PULSE;
            S_PULSE: begin
                if (pulse_last) begin
                    if (cur_op != OP_READMEM)        state_d = S_NEXT;
                    else if (cfg_adc_first == '0)    state_d = S_ADC_HIGH;
                    else                             state_d = S_ADC_FIRST;
                end
            end
            S_ADC_FIRST: begin
                cnt_d = cnt_q + ADC_DLY_W'(1);
                if (cnt_q == cfg_adc_first - ADC_DLY_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_ADC_HIGH;
                end
            end
            S_ADC_HIGH: begin
                cnt_d = cnt_q + ADC_DLY_W'(1);
                if (cnt_q == cfg_adc_high) begin
                    cnt_d   = '0;
                    state_d = (cfg_adc_low == '0) ? after_adc : S_ADC_LOW;
`ifdef READ_ACCUM_EN
                    res_d     = sat_add(res_q, ACC_W'(dout));
                    acc_vld_d = 1'b1;
`else
                    res_d     = dout;
`endif
                end
            end
            S_ADC_LOW: begin
                cnt_d = cnt_q + ADC_DLY_W'(1);
                if (cnt_q == cfg_adc_low - ADC_DLY_W'(1)) begin
                    cnt_d   = '0;
                    state_d = after_adc;
                end
            end
            S_PUSH: begin
                if (rd_ready) begin
                    state_d = S_NEXT;
`ifdef READ_ACCUM_EN
                    res_d     = '0;
                    acc_vld_d = 1'b0;
`endif
                end
            end
            S_NEXT: begin
`ifdef READ_ACCUM_EN
                push_pt = point_last && acc_vld_q;
`endif
                if (push_pt) begin
                    state_d = S_PUSH;
                end else begin
                    // Compare against the end value before incrementing so a
                    // range ending at the all-ones address never wraps.
                    state_d = S_SETUP;
                    if (slot_q != cfg_slot_num - 3'd1) begin
                        slot_d = slot_q + 3'd1;
                    end else begin
                        slot_d = '0;
                        if (l1_q != cfg_l1_loop) begin
                            l1_d = l1_q + LOOP_W'(1);
                        end else begin
                            l1_d = '0;
                            if (bl_q != cfg_bl_end) begin
                                bl_d = bl_q + BL_W'(1);
                            end else begin
                                bl_d = cfg_bl_st;
                                if (wl_q != cfg_wl_end) begin
                                    wl_d = wl_q + WL_W'(1);
                                end else begin
                                    wl_d = cfg_wl_st;
                                    if (l4_q != cfg_l4_loop) l4_d = l4_q + LOOP_W'(1);
                                    else                     state_d = S_DONE;
                                end
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort) state_d = S_IDLE;
    end

    // Outputs
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        op_sel   = busy ? cur_op : OP_SET;
        set_o    = (state_q == S_PULSE) && (cur_op == OP_SET);
        reset_o  = (state_q == S_PULSE) && (cur_op == OP_RESET);
        clkadc   = (state_q == S_ADC_HIGH);
        rd_valid = (state_q == S_PUSH);
        rd_data  = rd_valid ? {wl_q, bl_q, res_q} : '0;
        wl_addr  = wl_q;
        bl_addr  = bl_q;
        err      = err_q;
        st_slot  = slot_q;
        st_l1    = l1_q;
        st_l4    = l4_q;
    end

endmodule

// File: tb/tb_npu_array_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_npu_array_scan_seq
// Directed bench for npu_array_scan_seq with hand-computed expectations.
// Honours READ_ACCUM_EN the same way as the design (accumulated results).
// ---------------------------------------------------------------------------
module tb_npu_array_scan_seq;
    import npu_scan_pkg::*;

    localparam int WL_W = 8, BL_W = 8, NUM_SLOTS = 4, DOUT_W = 6;
    localparam int LOOP_W = 32, ADC_DLY_W = 12;
`ifdef READ_ACCUM_EN
    localparam int RES_W = ACC_W;
`else
    localparam int RES_W = DOUT_W;
`endif
    localparam int RD_W = WL_W + BL_W + RES_W;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, abort = 1'b0;
    logic [WL_W-1:0] cfg_wl_st, cfg_wl_end;
    logic [BL_W-1:0] cfg_bl_st, cfg_bl_end;
    logic [2:0] cfg_slot_num;
    logic [2*NUM_SLOTS-1:0] cfg_slot_mode;
    pulse_cfg_t [2:0] cfg_pulse;
    logic [LOOP_W-1:0] cfg_l1_loop, cfg_l4_loop;
    logic [ADC_DLY_W-1:0] cfg_adc_first, cfg_adc_high, cfg_adc_low;
    logic [WL_W-1:0] wl_addr;
    logic [BL_W-1:0] bl_addr;
    logic wl_en, sel_en, bl_en, set_o, reset_o, clkadc;
    logic [1:0] op_sel;
    logic [DOUT_W-1:0] dout;
    logic rd_valid, rd_ready;
    logic [RD_W-1:0] rd_data;
    logic busy, done, err;
    logic [2:0] st_slot;
    logic [LOOP_W-1:0] st_l1, st_l4;

    logic dout_tie_bl = 1'b1;
    logic [DOUT_W-1:0] dout_val = '0;
    assign dout = dout_tie_bl ? bl_addr[DOUT_W-1:0] : dout_val;

    always #5 clk = ~clk;

    npu_array_scan_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_wl_st(cfg_wl_st), .cfg_wl_end(cfg_wl_end),
        .cfg_bl_st(cfg_bl_st), .cfg_bl_end(cfg_bl_end),
        .cfg_slot_num(cfg_slot_num), .cfg_slot_mode(cfg_slot_mode),
        .cfg_pulse(cfg_pulse), .cfg_l1_loop(cfg_l1_loop), .cfg_l4_loop(cfg_l4_loop),
        .cfg_adc_first(cfg_adc_first), .cfg_adc_high(cfg_adc_high), .cfg_adc_low(cfg_adc_low),
        .wl_addr(wl_addr), .bl_addr(bl_addr), .wl_en(wl_en), .sel_en(sel_en), .bl_en(bl_en),
        .set_o(set_o), .reset_o(reset_o), .clkadc(clkadc), .op_sel(op_sel), .dout(dout),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .st_slot(st_slot), .st_l1(st_l1), .st_l4(st_l4)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor (samples on falling edge) ----------------
    // mon: 0 wl_en, 1 sel_en, 2 bl_en, 3 set_o, 4 reset_o, 5 done, 6 clkadc cycles
    int mon[7];
    int cyc = 0;
    int busy_rise_cyc = 0;
    logic [RD_W-1:0] push_data[$];
    int push_cyc[$];
    int ops[$];
    logic p_set = 1'b0, p_rst = 1'b0, p_adc = 1'b0, p_busy = 1'b0;

    initial for (int i = 0; i < 7; i++) mon[i] = 0;

    always @(negedge clk) begin
        cyc++;
        if (wl_en)   mon[0]++;
        if (sel_en)  mon[1]++;
        if (bl_en)   mon[2]++;
        if (set_o)   mon[3]++;
        if (reset_o) mon[4]++;
        if (done)    mon[5]++;
        if (clkadc)  mon[6]++;
        if (reset_o && !p_rst) ops.push_back(1);
        if (set_o && !p_set)   ops.push_back(0);
        if (clkadc && !p_adc)  ops.push_back(2);
        if (busy && !p_busy)   busy_rise_cyc = cyc;
        if (rd_valid && rd_ready) begin
            push_data.push_back(rd_data);
            push_cyc.push_back(cyc);
        end
        p_set = set_o; p_rst = reset_o; p_adc = clkadc; p_busy = busy;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int k;
        k = 0;
        while (busy && k < max) begin
            tick();
            k++;
        end
        check({tag, " timeout"}, busy, 1'b0);
    endtask

    function automatic pulse_cfg_t mk(input int pw, input int ws, input int we,
                                      input int ss, input int se, input int bs, input int be);
        pulse_cfg_t c;
        c.pw = PW_W'(pw);   c.wl_st = PW_W'(ws); c.wl_end = PW_W'(we);
        c.sel_st = PW_W'(ss); c.sel_end = PW_W'(se);
        c.bl_st = PW_W'(bs); c.bl_end = PW_W'(be);
        return c;
    endfunction

    task automatic cfg_base();
        cfg_wl_st = '0; cfg_wl_end = '0; cfg_bl_st = '0; cfg_bl_end = '0;
        cfg_slot_num = 3'd1; cfg_slot_mode = 8'hFE;
        cfg_l1_loop = '0; cfg_l4_loop = '0;
        cfg_adc_first = '0; cfg_adc_high = '0; cfg_adc_low = '0;
        cfg_pulse[0] = mk(0, 0, 0, 0, 0, 0, 0);
        cfg_pulse[1] = mk(0, 0, 0, 0, 0, 0, 0);
        cfg_pulse[2] = mk(0, 0, 0, 0, 0, 0, 0);
        dout_tie_bl = 1'b1; rd_ready = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base[7];
        int p0, o0, bnd;
        logic [RD_W-1:0] held;
        logic stable, quiet;

        cfg_base();
        cfg_slot_mode = 8'hAA;   // non-zero config must not leak onto op_sel
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",     busy, 1'b0);
        check("reset done",     done, 1'b0);
        check("reset err",      err, 1'b0);
        check("reset rd_valid", rd_valid, 1'b0);
        check("reset rd_data",  rd_data, '0);
        check("reset op_sel",   op_sel, 2'd0);
        check("reset enables",  {wl_en, sel_en, bl_en, set_o, reset_o, clkadc}, 6'd0);
        check("reset addr",     {wl_addr, bl_addr, st_slot}, '0);
        check("reset loops",    {st_l1, st_l4}, '0);
        rst_n = 1'b0;
        tick();

        // ---- T1: READMEM scan BL 0..7, timing per point ----
        cfg_base();
        cfg_bl_end = 8'd7;
        cfg_slot_mode = 8'hFE;                 // slot0 = READMEM
        cfg_pulse[2] = mk(19, 0, 19, 0, 19, 0, 19);
        cfg_adc_first = 12'd40; cfg_adc_high = 12'd10; cfg_adc_low = 12'd0;
        base = mon; p0 = push_data.size();
        pulse_start();
        wait_idle("t1", 2000);
        check("t1 pushes", push_data.size() - p0, 8);
        for (int i = 0; i < 8 && p0 + i < push_data.size(); i++)
            check($sformatf("t1 data%0d", i), push_data[p0 + i], {8'd0, 8'(i), RES_W'(i)});
        if (push_data.size() >= p0 + 2) begin
            check("t1 first latency", push_cyc[p0] - busy_rise_cyc, 73);
            check("t1 point period",  push_cyc[p0 + 1] - push_cyc[p0], 74);
        end
        check("t1 clkadc cycles", mon[6] - base[6], 88);
        check("t1 done",          mon[5] - base[5], 1);

        // ---- T2: SET windows ----
        cfg_base();
        cfg_slot_mode = 8'hFC;                 // slot0 = SET
        cfg_pulse[0] = mk(19, 1, 18, 3, 16, 5, 14);
        base = mon; p0 = push_data.size();
        pulse_start();
        wait_idle("t2", 200);
        check("t2 wl_en",   mon[0] - base[0], 18);
        check("t2 sel_en",  mon[1] - base[1], 14);
        check("t2 bl_en",   mon[2] - base[2], 10);
        check("t2 set_o",   mon[3] - base[3], 20);
        check("t2 reset_o", mon[4] - base[4], 0);
        check("t2 pushes",  push_data.size() - p0, 0);
        check("t2 done",    mon[5] - base[5], 1);

        // ---- T2b: RESET with clipped and empty windows ----
        cfg_slot_mode = 8'hFD;                 // slot0 = RESET
        cfg_pulse[1] = mk(9, 2, 100, 5, 3, 0, 9);
        base = mon;
        pulse_start();
        wait_idle("t2b", 200);
        check("t2b wl_en clip",  mon[0] - base[0], 8);
        check("t2b sel_en empty", mon[1] - base[1], 0);
        check("t2b bl_en",       mon[2] - base[2], 10);
        check("t2b reset_o",     mon[4] - base[4], 10);
        check("t2b set_o",       mon[3] - base[3], 0);

        // ---- T3: slots R,S,M with L1=1, L4=1, BL 2..3 ----
        cfg_base();
        cfg_slot_num = 3'd3;
        cfg_slot_mode = 8'hE1;                 // R, S, M, NOP
        cfg_bl_st = 8'd2; cfg_bl_end = 8'd3;
        cfg_l1_loop = 32'd1; cfg_l4_loop = 32'd1;
        cfg_pulse[0] = mk(1, 0, 1, 0, 1, 0, 1);
        cfg_pulse[1] = mk(1, 0, 1, 0, 1, 0, 1);
        cfg_pulse[2] = mk(1, 0, 1, 0, 1, 0, 1);
        base = mon; p0 = push_data.size(); o0 = ops.size();
        pulse_start();
        wait_idle("t3", 1000);
        check("t3 op count", ops.size() - o0, 24);
        for (int k = 0; k < 24 && o0 + k < ops.size(); k++)
            check($sformatf("t3 op%0d", k), ops[o0 + k], (k % 3 == 0) ? 1 : (k % 3 == 1) ? 0 : 2);
`ifdef READ_ACCUM_EN
        check("t3 pushes", push_data.size() - p0, 4);
        for (int k = 0; k < 4 && p0 + k < push_data.size(); k++)
            check($sformatf("t3 data%0d", k), push_data[p0 + k],
                  {8'd0, 8'(2 + k % 2), RES_W'(2 * (2 + k % 2))});
`else
        check("t3 pushes", push_data.size() - p0, 8);
        for (int k = 0; k < 8 && p0 + k < push_data.size(); k++)
            check($sformatf("t3 data%0d", k), push_data[p0 + k],
                  {8'd0, 8'(2 + (k / 2) % 2), RES_W'(2 + (k / 2) % 2)});
`endif
        check("t3 st_l4", st_l4, 32'd1);
        check("t3 done",  mon[5] - base[5], 1);

        // ---- T4: backpressure in PUSH ----
        cfg_base();
        cfg_bl_end = 8'd1;
        cfg_pulse[2] = mk(3, 0, 3, 0, 3, 0, 3);
        cfg_adc_first = 12'd2; cfg_adc_high = 12'd1; cfg_adc_low = 12'd2;
        rd_ready = 1'b0;
        base = mon; p0 = push_data.size();
        pulse_start();
        bnd = 0;
        while (!rd_valid && bnd < 200) begin tick(); bnd++; end
        check("t4 valid reached", rd_valid, 1'b1);
        held = rd_data; stable = 1'b1; quiet = 1'b1;
        repeat (50) begin
            tick();
            if (!rd_valid || rd_data !== held) stable = 1'b0;
            if (wl_en | sel_en | bl_en | set_o | reset_o | clkadc) quiet = 1'b0;
        end
        check("t4 held data",   held, {8'd0, 8'd0, RES_W'(0)});
        check("t4 stable",      stable, 1'b1);
        check("t4 quiet",       quiet, 1'b1);
        rd_ready = 1'b1;
        wait_idle("t4", 300);
        check("t4 pushes", push_data.size() - p0, 2);
        if (push_data.size() >= p0 + 2)
            check("t4 data1", push_data[p0 + 1], {8'd0, 8'd1, RES_W'(1)});
        check("t4 done",   mon[5] - base[5], 1);

        // ---- T5: config errors ----
        cfg_base();
        cfg_bl_st = 8'd5; cfg_bl_end = 8'd3;
        base = mon;
        pulse_start();
        tick(); tick();
        check("t5 err bl",   err, 1'b1);
        check("t5 busy",     busy, 1'b0);
        check("t5 no done",  mon[5] - base[5], 0);
        cfg_base();
        cfg_slot_num = 3'd0;
        pulse_start(); tick(); tick();
        check("t5 err slot0", err, 1'b1);
        cfg_slot_num = 3'd5;
        pulse_start(); tick(); tick();
        check("t5 err slot5", err, 1'b1);

        // ---- T6: ranges ending at all-ones, clears err ----
        cfg_base();
        cfg_wl_st = 8'd255; cfg_wl_end = 8'd255;
        cfg_bl_st = 8'd254; cfg_bl_end = 8'd255;
        base = mon; p0 = push_data.size();
        pulse_start();
        wait_idle("t6", 100);
        check("t6 err cleared", err, 1'b0);
        check("t6 pushes", push_data.size() - p0, 2);
        if (push_data.size() >= p0 + 2) begin
            check("t6 data0", push_data[p0],     {8'd255, 8'd254, RES_W'(62)});
            check("t6 data1", push_data[p0 + 1], {8'd255, 8'd255, RES_W'(63)});
        end
        check("t6 done", mon[5] - base[5], 1);

        // ---- T7: abort mid-PULSE ----
        cfg_base();
        cfg_slot_mode = 8'hFC;
        cfg_pulse[0] = mk(19, 0, 19, 0, 19, 0, 19);
        base = mon;
        pulse_start();
        bnd = 0;
        while (!set_o && bnd < 20) begin tick(); bnd++; end
        check("t7 in pulse", set_o, 1'b1);
        tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t7 outputs after abort", {wl_en, sel_en, bl_en, set_o, busy}, 5'd0);
        repeat (30) tick();
        check("t7 no done", mon[5] - base[5], 0);
        check("t7 idle",    busy, 1'b0);

        // ---- T8: start and abort together ----
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("t8 abort wins", busy, 1'b0);

`ifdef READ_ACCUM_EN
        // ---- T9: accumulation and saturation ----
        cfg_base();
        dout_tie_bl = 1'b0; dout_val = 6'd63;
        cfg_l1_loop = 32'd3;
        p0 = push_data.size();
        pulse_start();
        wait_idle("t9", 200);
        check("t9 pushes", push_data.size() - p0, 1);
        if (push_data.size() > p0) check("t9 acc", push_data[p0], {8'd0, 8'd0, 16'd252});
        cfg_l1_loop = 32'd1099;
        p0 = push_data.size();
        pulse_start();
        wait_idle("t9 sat", 6000);
        check("t9 sat pushes", push_data.size() - p0, 1);
        if (push_data.size() > p0) check("t9 sat", push_data[p0], {8'd0, 8'd0, 16'd65535});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
